imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single port of the 64-word instruction memory between two requesters: instruction fetch (F) and a debug/loader data port (D).
- D may read or write program memory at run time, e.g. to patch trap vectors or load programs.
- Fixed priority to F, with a starvation guard for D.
- One request accepted per cycle, 1-cycle memory read latency, valid/ready handshakes on both request and response sides.
- Sits between the core fetch stage / debug bridge and the synchronous-read imem RAM.

Parameters:
- N, 32, data word width
- ADDR_W, 6, word address width (64 words)
- MAX_WAIT, 4, consecutive lost arbitrations after which D is granted ahead of F (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_W  fetch word address
- f_rsp_valid  out  1  fetch read data valid
- f_rsp_ready  in  1  fetch consumer accepts response
- f_rsp_data  out  N  fetch read data
- d_req_valid  in  1  debug request valid
- d_req_ready  out  1  debug request accepted this cycle
- d_req_addr  in  ADDR_W  debug word address
- d_req_we  in  1  1 = write, 0 = read
- d_req_wdata  in  N  debug write data
- d_rsp_valid  out  1  debug response valid (read data or write ack)
- d_rsp_ready  in  1  debug consumer accepts response
- d_rsp_data  out  N  read data; 0 for write acks
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid the cycle after mem_addr is presented
- grant_d  out  1  1 when the current cycle's accept goes to D (debug visibility)

Behaviour:
- Reset values: all *_ready, *_rsp_valid, mem_we and grant_d = 0; *_rsp_data = 0; mem_addr = 0; wait counter = 0; response slot = EMPTY.
- Response slot: single entry, owner in {NONE, F, D}.
  - slot_free = (owner == NONE) or (the owner's rsp_valid and rsp_ready are both 1 this cycle).
  - Throughput: 1 request/cycle when consumers are always ready.
- Arbitration (combinational, only when slot_free):
  - wait counter == MAX_WAIT and d_req_valid: grant D.
  - else f_req_valid: grant F.
  - else d_req_valid: grant D.
  - else: no grant.
- Accept:
  - Granted port's req_ready = 1; the other port's req_ready = 0.
  - mem_addr/mem_we/mem_wdata are driven from the granted request in the same cycle.
  - mem_we = 1 only for a D write.
  - With no grant, mem_we = 0 and mem_addr holds its previous value.
- Latency: a request accepted at cycle t gives rsp_valid at cycle t+1.
  - At t+1, rsp_data comes from mem_rdata and is captured into a hold register.
  - From t+2 onward, rsp_data is driven from the hold register until rsp_ready.
  - rsp_valid is held stable until accepted; data must not change while stalled.
- D writes: the memory is updated at the accept edge. The ack (d_rsp_valid, data 0) appears at t+1.
- Read-after-write:
  - A read of the same address accepted at t+1 returns the new data.
  - A D write and an F read are never accepted in the same cycle (single port).
- Wait counter:
  - Increments (saturating at MAX_WAIT) in each cycle where d_req_valid = 1, slot_free = 1 and F is granted.
  - Clears on any D accept.
  - Holds otherwise, including when no request is accepted because the slot is stalled.
- Backpressure: while the slot owner stalls (rsp_ready = 0), both req_ready = 0, even for the other port.
- Reset mid-operation: the outstanding response is dropped immediately (asynchronous), and the counter and slot clear. Any write already accepted before reset stays in memory.
- Response exclusivity: f_rsp_valid and d_rsp_valid are never 1 in the same cycle.

Decomposition:
- Package imem_pkg:
  - ADDR_W and N defaults.
  - slot_owner_t enum {OWN_NONE, OWN_F, OWN_D}.
  - MAX_WAIT default.
- One sub-module is natural: imem_resp_slot (owner register, hold register, valid/ready handling, slot_free output).
- Arbitration and the wait counter stay in the top module.

Test Plan:
- Reset, then F reads addr 3 with f_rsp_ready = 1 -> f_req_ready at cycle 0, f_rsp_valid at cycle 1 with the word at addr 3; mem_we stays 0.
- F continuous at addr 0..9 while D requests a read of addr 5, MAX_WAIT = 4 -> F accepted for 4 cycles, D granted on the 5th cycle (grant_d = 1), counter then 0, F resumes the next cycle.
- D writes 0xDEADBEEF to addr 7, then reads addr 7 back-to-back -> write ack at t+1 with d_rsp_data = 0; read returns 0xDEADBEEF at t+2.
- F read with f_rsp_ready held 0 for 3 cycles while D is valid -> f_rsp_data stable for all 4 cycles, d_req_ready = 0 throughout, wait counter unchanged; D accepted in the cycle f_rsp_ready = 1.
- Assert reset with an F response pending -> f_rsp_valid = 0 immediately; after release, no stale response appears and the first new request behaves as in scenario 1.
- Random F/D traffic against a reference memory model -> every response matches the model, no two *_rsp_valid high together, and no response is lost or duplicated.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// The slot owner records which requester the single pending response belongs to.
package imem_pkg;

  localparam int N_DEF        = 32;
  localparam int ADDR_W_DEF   = 6;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } slot_owner_t;

endpackage

// File: rtl/imem_resp_slot.sv
// Single-entry response slot: tracks which port owns the pending response and
// holds its data stable from the second cycle onward until the consumer accepts.
module imem_resp_slot
  import imem_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         accept_f,
  input  logic         accept_d,
  input  logic         accept_we,
  input  logic         f_rsp_ready,
  input  logic         d_rsp_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         f_rsp_valid,
  output logic [N-1:0] f_rsp_data,
  output logic         d_rsp_valid,
  output logic [N-1:0] d_rsp_data,
  output logic         slot_free
);

  slot_owner_t  owner_r;
  logic         first_r;
  logic         wr_r;
  logic [N-1:0] hold_r;
  logic [N-1:0] cur_data_s;
  logic         slot_free_s;

  // Response data selection and slot-free decode
  always_comb begin
    cur_data_s  = {N{1'b0}};
    slot_free_s = 1'b1;
    if (first_r) begin
      cur_data_s = wr_r ? {N{1'b0}} : mem_rdata;
    end else begin
      cur_data_s = hold_r;
    end
    case (owner_r)
      OWN_NONE: slot_free_s = 1'b1;
      OWN_F:    slot_free_s = f_rsp_ready;
      OWN_D:    slot_free_s = d_rsp_ready;
      default:  slot_free_s = 1'b1;
    endcase
  end

  assign slot_free   = slot_free_s;
  assign f_rsp_valid = (owner_r == OWN_F);
  assign d_rsp_valid = (owner_r == OWN_D);
  assign f_rsp_data  = (owner_r == OWN_F) ? cur_data_s : {N{1'b0}};
  assign d_rsp_data  = (owner_r == OWN_D) ? cur_data_s : {N{1'b0}};

  // Owner, first-cycle flag and hold register; a new accept refills the slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= OWN_NONE;
      first_r <= 1'b0;
      wr_r    <= 1'b0;
      hold_r  <= {N{1'b0}};
    end else begin
      if (first_r) begin
        hold_r <= cur_data_s;
      end
      if (accept_f) begin
        owner_r <= OWN_F;
        first_r <= 1'b1;
        wr_r    <= 1'b0;
      end else if (accept_d) begin
        owner_r <= OWN_D;
        first_r <= 1'b1;
        wr_r    <= accept_we;
      end else if (slot_free_s) begin
        owner_r <= OWN_NONE;
        first_r <= 1'b0;
        wr_r    <= 1'b0;
      end else begin
        first_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single imem port between fetch (F) and debug/loader (D): fixed
// priority to F, with a wait counter that forces a D grant after MAX_WAIT losses.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [N-1:0]      f_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [N-1:0]      d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [N-1:0]      d_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [N-1:0]      mem_wdata,
  input  logic [N-1:0]      mem_rdata,
  output logic              grant_d
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              slot_free_s;
  logic              grant_f_s;
  logic              grant_d_s;

  // Arbitration and memory-port drive; the port idles on its last address
  always_comb begin
    grant_f_s  = 1'b0;
    grant_d_s  = 1'b0;
    mem_addr_s = last_addr_r;
    if (!reset && slot_free_s) begin
      if (d_req_valid && ((wait_r == WAIT_MAX) || !f_req_valid)) begin
        grant_d_s = 1'b1;
      end else if (f_req_valid) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
      end
    end else begin
      grant_f_s = 1'b0;
    end
    if (grant_d_s) begin
      mem_addr_s = d_req_addr;
    end else if (grant_f_s) begin
      mem_addr_s = f_req_addr;
    end else begin
      mem_addr_s = last_addr_r;
    end
  end

  assign f_req_ready = grant_f_s;
  assign d_req_ready = grant_d_s;
  assign grant_d     = grant_d_s;
  assign mem_addr    = mem_addr_s;
  assign mem_we      = grant_d_s & d_req_we;
  assign mem_wdata   = grant_d_s ? d_req_wdata : {N{1'b0}};

  // Starvation counter and idle-address register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_r      <= {WAIT_W{1'b0}};
      last_addr_r <= {ADDR_W{1'b0}};
    end else begin
      last_addr_r <= mem_addr_s;
      if (grant_d_s) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (grant_f_s && d_req_valid && (wait_r != WAIT_MAX)) begin
        wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  imem_resp_slot #(.N(N)) u_slot (
    .clk         (clk),
    .reset       (reset),
    .accept_f    (grant_f_s),
    .accept_d    (grant_d_s),
    .accept_we   (d_req_we),
    .f_rsp_ready (f_rsp_ready),
    .d_rsp_ready (d_rsp_ready),
    .mem_rdata   (mem_rdata),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_data  (f_rsp_data),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .slot_free   (slot_free_s)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random F/D traffic checked
// against a reference memory and a single-slot response model.
module tb_imem_port_arbiter;

  localparam int N        = 32;
  localparam int ADDR_W   = 6;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic [N-1:0]      f_rsp_data;
  logic              d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [N-1:0]      d_req_wdata, d_rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, grant_d;
  logic [N-1:0]      mem_wdata, mem_rdata;

  logic [N-1:0] ram [64];
  logic [N-1:0] ref_mem [64];
  logic         init_en;
  int           vectors;
  int           miscompares;

  imem_port_arbiter #(.N(N), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Synchronous-read instruction RAM (read-first)
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0; d_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, mem_we, grant_d} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, mem_we, grant_d});
    end
    vectors++;
    if ({f_rsp_data, d_rsp_data, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: f=%h d=%h addr=%h expected all 0", f_rsp_data, d_rsp_data, mem_addr);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_fetch_read();
    do_reset();
    f_req_valid = 1'b1; f_req_addr = 6'd3;
    @(negedge clk);
    vectors++;
    if ({f_req_ready, d_req_ready, grant_d, mem_we} !== 4'b1000 || mem_addr !== 6'd3) begin
      miscompares++;
      $display("FAIL fetch_accept: got rdy/gd/we=%b addr=%0d expected 1000 addr=3",
               {f_req_ready, d_req_ready, grant_d, mem_we}, mem_addr);
    end
    next_cycle();
    f_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({f_rsp_valid, d_rsp_valid} !== 2'b10 || f_rsp_data !== ref_mem[3] || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_rsp: got v=%b data=%h we=%b expected v=10 data=%h we=0",
               {f_rsp_valid, d_rsp_valid}, f_rsp_data, mem_we, ref_mem[3]);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (f_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_rsp_done: got %b expected 0", f_rsp_valid);
    end
  endtask

  task automatic test_starvation();
    int   faddr;
    logic exp_gd, prev_f;
    logic [ADDR_W-1:0] prev_addr;
    logic [N-1:0] exp_data, act_data;
    do_reset();
    faddr = 0; prev_f = 1'b0; prev_addr = '0;
    for (int k = 0; k < 10; k++) begin
      f_req_valid = 1'b1; f_req_addr = 6'(faddr);
      d_req_valid = 1'b1; d_req_addr = 6'd5; d_req_we = 1'b0;
      @(negedge clk);
      exp_gd = (k == 4) || (k == 9);
      vectors++;
      if ({f_req_ready, d_req_ready, grant_d} !== {!exp_gd, exp_gd, exp_gd} ||
          mem_addr !== (exp_gd ? 6'd5 : 6'(faddr))) begin
        miscompares++;
        $display("FAIL starve_grant[%0d]: got f/d/gd=%b addr=%0d expected %b addr=%0d", k,
                 {f_req_ready, d_req_ready, grant_d}, mem_addr, {!exp_gd, exp_gd, exp_gd},
                 exp_gd ? 5 : faddr);
      end
      if (k > 0) begin
        exp_data = prev_f ? ref_mem[prev_addr] : ref_mem[5];
        act_data = prev_f ? f_rsp_data : d_rsp_data;
        vectors++;
        if ({f_rsp_valid, d_rsp_valid} !== {prev_f, !prev_f} || act_data !== exp_data) begin
          miscompares++;
          $display("FAIL starve_rsp[%0d]: got v=%b data=%h expected v=%b data=%h", k,
                   {f_rsp_valid, d_rsp_valid}, act_data, {prev_f, !prev_f}, exp_data);
        end
      end
      prev_f = !exp_gd;
      prev_addr = 6'(faddr);
      if (!exp_gd) faddr++;
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_write_readback();
    do_reset();
    d_req_valid = 1'b1; d_req_addr = 6'd7; d_req_we = 1'b1; d_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({d_req_ready, grant_d, mem_we} !== 3'b111 || mem_addr !== 6'd7 || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wr_accept: got rdy/gd/we=%b addr=%0d wdata=%h expected 111 7 deadbeef",
               {d_req_ready, grant_d, mem_we}, mem_addr, mem_wdata);
    end
    ref_mem[7] = 32'hDEAD_BEEF;
    next_cycle();
    d_req_we = 1'b0; d_req_wdata = '0;
    @(negedge clk);
    vectors++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0 || d_req_ready !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ack: got v=%b data=%h rdy=%b we=%b expected 1 0 1 0",
               d_rsp_valid, d_rsp_data, d_req_ready, mem_we);
    end
    next_cycle();
    d_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL raw_read: got v=%b data=%h expected 1 deadbeef", d_rsp_valid, d_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    do_reset();
    f_req_valid = 1'b1; f_req_addr = 6'd9; f_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 6'd2; d_req_we = 1'b0; d_rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({f_req_ready, d_req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_first: got %b expected 10", {f_req_ready, d_req_ready});
    end
    next_cycle();
    f_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      f_rsp_ready = (c == 4);
      @(negedge clk);
      vectors++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== ref_mem[9] || f_req_ready !== 1'b0 ||
          {d_req_ready, grant_d} !== ((c == 4) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b data=%h frdy=%b drdy/gd=%b expected 1 %h 0 %b", c,
                 f_rsp_valid, f_rsp_data, f_req_ready, {d_req_ready, grant_d}, ref_mem[9],
                 (c == 4) ? 2'b11 : 2'b00);
      end
      next_cycle();
    end
    d_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({f_rsp_valid, d_rsp_valid} !== 2'b01 || d_rsp_data !== ref_mem[2]) begin
      miscompares++;
      $display("FAIL stall_drsp: got v=%b data=%h expected 01 %h", {f_rsp_valid, d_rsp_valid},
               d_rsp_data, ref_mem[2]);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    d_req_valid = 1'b1; d_req_addr = 6'd20; d_req_we = 1'b1; d_req_wdata = 32'h1234_5678;
    next_cycle();
    ref_mem[20] = 32'h1234_5678;
    d_req_valid = 1'b0; d_req_we = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 6'd11; f_rsp_ready = 1'b0;
    next_cycle();
    f_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pending: got %b expected 1", f_rsp_valid);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({f_rsp_valid, d_rsp_valid} !== 2'b00 || f_rsp_data !== '0) begin
      miscompares++;
      $display("FAIL midrst_drop: got v=%b data=%h expected 00 0", {f_rsp_valid, d_rsp_valid}, f_rsp_data);
    end
    next_cycle();
    reset = 1'b0;
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({f_rsp_valid, d_rsp_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL midrst_stale[%0d]: got %b expected 00", c, {f_rsp_valid, d_rsp_valid});
      end
      next_cycle();
    end
    f_req_valid = 1'b1; f_req_addr = 6'd20;
    @(negedge clk);
    vectors++;
    if (f_req_ready !== 1'b1 || mem_addr !== 6'd20) begin
      miscompares++;
      $display("FAIL midrst_accept: got rdy=%b addr=%0d expected 1 20", f_req_ready, mem_addr);
    end
    next_cycle();
    f_req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (f_rsp_valid !== 1'b1 || f_rsp_data !== ref_mem[20]) begin
      miscompares++;
      $display("FAIL midrst_persist: got v=%b data=%h expected 1 %h", f_rsp_valid, f_rsp_data, ref_mem[20]);
    end
    next_cycle();
  endtask

  task automatic test_random();
    int owner, mwait, issued, handshakes;
    logic [N-1:0] mdata;
    logic [ADDR_W-1:0] last_addr, exp_addr;
    logic free, gd, gf;
    do_reset();
    owner = 0; mwait = 0; issued = 0; handshakes = 0; mdata = '0; last_addr = '0;
    for (int i = 0; i < 640; i++) begin
      if (i < 600) begin
        f_req_valid = ($urandom_range(0, 9) < 8);
        f_req_addr  = 6'($urandom_range(0, 15));
        f_rsp_ready = ($urandom_range(0, 9) < 7);
        d_req_valid = ($urandom_range(0, 1) == 1);
        d_req_addr  = 6'($urandom_range(0, 15));
        d_req_we    = ($urandom_range(0, 9) < 3);
        d_req_wdata = $urandom;
        d_rsp_ready = ($urandom_range(0, 9) < 7);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      free = (owner == 0) || (owner == 1 && f_rsp_ready) || (owner == 2 && d_rsp_ready);
      gd = free && d_req_valid && (mwait == MAX_WAIT || !f_req_valid);
      gf = free && f_req_valid && !gd;
      exp_addr = gd ? d_req_addr : (gf ? f_req_addr : last_addr);
      vectors++;
      if ({f_req_ready, d_req_ready, grant_d, mem_we} !== {gf, gd, gd, gd && d_req_we} ||
          mem_addr !== exp_addr || (gd && d_req_we && mem_wdata !== d_req_wdata)) begin
        miscompares++;
        $display("FAIL rand_arb[%0d]: got f/d/gd/we=%b addr=%0d expected %b addr=%0d", i,
                 {f_req_ready, d_req_ready, grant_d, mem_we}, mem_addr,
                 {gf, gd, gd, gd && d_req_we}, exp_addr);
      end
      vectors++;
      if ({f_rsp_valid, d_rsp_valid} !== {owner == 1, owner == 2} ||
          (owner == 1 && f_rsp_data !== mdata) || (owner == 2 && d_rsp_data !== mdata)) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: got v=%b f=%h d=%h expected v=%b data=%h", i,
                 {f_rsp_valid, d_rsp_valid}, f_rsp_data, d_rsp_data,
                 {owner == 1, owner == 2}, mdata);
      end
      if ((f_rsp_valid && f_rsp_ready) || (d_rsp_valid && d_rsp_ready)) handshakes++;
      last_addr = exp_addr;
      if (gd) mwait = 0;
      else if (gf && d_req_valid && mwait < MAX_WAIT) mwait++;
      if (gf) begin
        owner = 1; mdata = ref_mem[f_req_addr]; issued++;
      end else if (gd) begin
        owner = 2; mdata = d_req_we ? '0 : ref_mem[d_req_addr]; issued++;
        if (d_req_we) ref_mem[d_req_addr] = d_req_wdata;
      end else if (free) begin
        owner = 0;
      end
      next_cycle();
    end
    vectors++;
    if (handshakes !== issued || owner != 0) begin
      miscompares++;
      $display("FAIL rand_count: got %0d responses consumed expected %0d accepted", handshakes, issued);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    init_en = 1'b1;
    drive_idle();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    next_cycle();
    init_en = 1'b0;
    test_reset();
    test_fetch_read();
    test_starvation();
    test_write_readback();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
